scroll_patterngen: RTL and testbench



---
 rtl/scroll_patterngen.sv | 181 ++++++++++++++++++
 tb/tb_scroll_patterngen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_patterngen.sv
// -----------------------------------------------------------------------------
// scroll_patterngen
// Frame-fill pattern generator for the LED panel framebuffer. On each accepted
// frame_tick it walks every pixel address, fetches the pixel from an external
// combinational image ROM (with optional horizontal/vertical scroll offset) and
// writes it through a ready/valid port, then flips the display buffer select.
//
// Optional feature: define PATGEN_DIM_EN to add a dim[1:0] input, latched at
// frame start, that right-shifts each 8-bit colour channel of rgb.
//
// Ports:
//   pixclk        clock, rising edge
//   reset         asynchronous, active-high
//   i_frame_tick  one-cycle pulse requesting a frame fill
//   i_switch_img  one-cycle pulse advancing the pending image index
//   i_mode        00 static, 01 scroll left, 10 scroll up, 11 diagonal
//   i_wr_ready    framebuffer accepts the current write
//   i_rom_rgb     combinational ROM data for {o_rom_img, o_rom_addr}
//   i_dim         (PATGEN_DIM_EN only) per-channel right shift
//   o_rom_addr    ROM pixel address {row, col} with scroll offset applied
//   o_rom_img     image index latched for the current frame
//   o_addr        framebuffer address {row, col}
//   o_rgb         pixel data, same-cycle pass-through of i_rom_rgb
//   o_write       write valid
//   o_display     buffer select, toggles once per completed frame
//   o_busy        high while filling
//   o_overrun     one-cycle pulse when a frame_tick arrives while busy
// -----------------------------------------------------------------------------
module scroll_patterngen #(
    parameter int unsigned COL_BITS    = 5,
    parameter int unsigned ROW_BITS    = 4,
    parameter int unsigned IMG_BITS    = 3,
    parameter int unsigned CNT_BITS    = 7,
    parameter int unsigned SPEED_SHIFT = 2
) (
    input  logic                         pixclk,
    input  logic                         reset,
    input  logic                         i_frame_tick,
    input  logic                         i_switch_img,
    input  logic [1:0]                   i_mode,
    input  logic                         i_wr_ready,
    input  logic [23:0]                  i_rom_rgb,
`ifdef PATGEN_DIM_EN
    input  logic [1:0]                   i_dim,
`endif
    output logic [COL_BITS+ROW_BITS-1:0] o_rom_addr,
    output logic [IMG_BITS-1:0]          o_rom_img,
    output logic [COL_BITS+ROW_BITS-1:0] o_addr,
    output logic [23:0]                  o_rgb,
    output logic                         o_write,
    output logic                         o_display,
    output logic                         o_busy,
    output logic                         o_overrun
);

    localparam int unsigned ADDR_BITS = COL_BITS + ROW_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SWAP
    } state_t;

    state_t                r_state;
    logic [ADDR_BITS-1:0]  r_frameaddr;
    logic [CNT_BITS-1:0]   r_framecount;
    logic [IMG_BITS-1:0]   r_pend_img;
    logic [IMG_BITS-1:0]   r_rom_img;
    logic [1:0]            r_mode;
    logic [COL_BITS-1:0]   r_hoff;
    logic [ROW_BITS-1:0]   r_voff;
    logic                  r_display;
    logic                  r_write;
    logic                  r_busy;
    logic                  r_overrun;
`ifdef PATGEN_DIM_EN
    logic [1:0]            r_dim;
`endif

    logic [COL_BITS-1:0]   w_col;
    logic [ROW_BITS-1:0]   w_row;
    logic [COL_BITS-1:0]   w_rom_col;
    logic [ROW_BITS-1:0]   w_rom_row;
    logic                  w_accept;
    logic                  w_last;

    assign w_col    = r_frameaddr[COL_BITS-1:0];
    assign w_row    = r_frameaddr[ADDR_BITS-1:COL_BITS];
    assign w_accept = r_write & i_wr_ready;
    assign w_last   = (r_frameaddr == {ADDR_BITS{1'b1}});

    // Scroll offsets wrap modulo the panel size (plain subtraction).
    assign w_rom_col = r_mode[0] ? (w_col - r_hoff) : w_col;
    assign w_rom_row = r_mode[1] ? (w_row - r_voff) : w_row;

    // Frame-fill FSM; all control outputs registered.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_frameaddr  <= '0;
            r_framecount <= '0;
            r_pend_img   <= '0;
            r_rom_img    <= '0;
            r_mode       <= 2'b00;
            r_hoff       <= '0;
            r_voff       <= '0;
            r_display    <= 1'b0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef PATGEN_DIM_EN
            r_dim        <= 2'b00;
`endif
        end else begin
            // Any tick outside IDLE (including the last-beat cycle) is an overrun.
            r_overrun <= i_frame_tick && (r_state != ST_IDLE);

            if (i_switch_img) begin
                r_pend_img <= r_pend_img + IMG_BITS'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_frame_tick) begin
                        r_mode      <= i_mode;
                        r_rom_img   <= r_pend_img;
                        r_hoff      <= COL_BITS'(r_framecount >> SPEED_SHIFT);
                        r_voff      <= ROW_BITS'(r_framecount >> SPEED_SHIFT);
`ifdef PATGEN_DIM_EN
                        r_dim       <= i_dim;
`endif
                        r_frameaddr <= '0;
                        r_write     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Without acceptance everything holds so valid never drops.
                    if (w_accept) begin
                        if (w_last) begin
                            r_write <= 1'b0;
                            r_state <= ST_SWAP;
                        end else begin
                            r_frameaddr <= r_frameaddr + ADDR_BITS'(1);
                        end
                    end
                end
                ST_SWAP: begin
                    r_display    <= ~r_display;
                    r_framecount <= r_framecount + CNT_BITS'(1);
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_write <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr = {w_rom_row, w_rom_col};
    assign o_rom_img  = r_rom_img;
    assign o_addr     = r_frameaddr;
    assign o_write    = r_write;
    assign o_display  = r_display;
    assign o_busy     = r_busy;
    assign o_overrun  = r_overrun;

`ifdef PATGEN_DIM_EN
    // Per-channel zero-filled right shift, still zero latency.
    assign o_rgb = {i_rom_rgb[23:16] >> r_dim,
                    i_rom_rgb[15:8]  >> r_dim,
                    i_rom_rgb[7:0]   >> r_dim};
`else
    assign o_rgb = i_rom_rgb;
`endif

endmodule

// File: tb/tb_scroll_patterngen.sv
module tb_scroll_patterngen;

    localparam int COLS = 32;
    localparam int ROWS = 16;
    localparam int NPIX = COLS * ROWS;

    logic        pixclk;
    logic        reset;
    logic        frame_tick;
    logic        switch_img;
    logic [1:0]  mode;
    logic        wr_ready;
    logic [23:0] rom_rgb;
    logic [8:0]  rom_addr;
    logic [2:0]  rom_img;
    logic [8:0]  addr;
    logic [23:0] rgb;
    logic        write;
    logic        display;
    logic        busy;
    logic        overrun;
`ifdef PATGEN_DIM_EN
    logic [1:0]  dim;
`endif

    int checks = 0;
    int failures = 0;

    scroll_patterngen dut (
        .pixclk      (pixclk),
        .reset       (reset),
        .i_frame_tick(frame_tick),
        .i_switch_img(switch_img),
        .i_mode      (mode),
        .i_wr_ready  (wr_ready),
        .i_rom_rgb   (rom_rgb),
`ifdef PATGEN_DIM_EN
        .i_dim       (dim),
`endif
        .o_rom_addr  (rom_addr),
        .o_rom_img   (rom_img),
        .o_addr      (addr),
        .o_rgb       (rgb),
        .o_write     (write),
        .o_display   (display),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    // Image ROM content: distinct per image and per address.
    function automatic logic [23:0] rom_fn(input logic [2:0] img, input logic [8:0] a);
        logic [15:0] lo;
        logic [3:0]  mid;
        lo  = 16'(a) * 16'd731 + 16'(img) * 16'd97;
        mid = 4'(a >> 5) ^ 4'hA;
        return {1'b0, img, mid, lo};
    endfunction

    function automatic logic [23:0] dim_fn(input logic [23:0] v, input int d);
        logic [7:0] r, g, b;
        r = v[23:16] >> d;
        g = v[15:8]  >> d;
        b = v[7:0]   >> d;
        return {r, g, b};
    endfunction

    // Expected ROM address for pixel index k under a frame's scroll settings.
    function automatic int exp_rom(input int k, input int md, input int hoff, input int voff);
        int col, row;
        col = k % COLS;
        row = k / COLS;
        if (md % 2 == 1) col = (col - hoff + COLS) % COLS;
        if (md / 2 == 1) row = (row - voff + ROWS) % ROWS;
        return row * COLS + col;
    endfunction

    assign rom_rgb = rom_fn(rom_img, rom_addr);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural frame model ----------------
    bit m_active, m_swap;
    int m_beat, m_fc, m_pend, m_img, m_mode, m_hoff, m_voff, m_dim, m_acc;
    bit m_disp, m_ovr;

    task automatic model_reset();
        m_active = 0; m_swap = 0; m_beat = 0; m_fc = 0; m_pend = 0;
        m_img = 0; m_mode = 0; m_hoff = 0; m_voff = 0; m_dim = 0;
        m_acc = 0; m_disp = 0; m_ovr = 0;
    endtask

    initial model_reset();

    // Compare process: outputs are stable at negedge; inputs are those the
    // next rising edge will act on.
    always @(negedge pixclk) begin
        int er;
        bit exp_write;
        logic [23:0] erg;
        if (reset) begin
            chk("rst_write", int'(write), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_display", int'(display), 0);
            chk("rst_overrun", int'(overrun), 0);
            chk("rst_rom_img", int'(rom_img), 0);
            model_reset();
        end else begin
            exp_write = m_active && !m_swap;
            chk("write", int'(write), int'(exp_write));
            chk("busy", int'(busy), int'(m_active));
            chk("display", int'(display), int'(m_disp));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("rom_img", int'(rom_img), m_img);
            if (exp_write) begin
                er  = exp_rom(m_beat, m_mode, m_hoff, m_voff);
                erg = dim_fn(rom_fn(3'(m_img), 9'(er)), m_dim);
                chk("addr", int'(addr), m_beat);
                chk("rom_addr", int'(rom_addr), er);
                chk("rgb", int'(rgb), int'(erg));
            end
            if (write && wr_ready) m_acc++;

            // advance model to the state after the coming edge
            m_ovr = frame_tick && m_active;
            if (!m_active) begin
                if (frame_tick) begin
                    m_active = 1; m_swap = 0; m_beat = 0; m_acc = 0;
                    m_img  = m_pend;
                    m_mode = int'(mode);
                    m_hoff = (m_fc >> 2) % COLS;
                    m_voff = (m_fc >> 2) % ROWS;
`ifdef PATGEN_DIM_EN
                    m_dim  = int'(dim);
`endif
                end
            end else if (m_swap) begin
                chk("beats_per_frame", m_acc, NPIX);
                m_active = 0; m_swap = 0;
                m_disp = !m_disp;
                m_fc = (m_fc + 1) % 128;
            end else if (wr_ready) begin
                if (m_beat == NPIX - 1) m_swap = 1;
                else m_beat++;
            end
            if (switch_img) m_pend = (m_pend + 1) % 8;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_addr(input int n);
        int t;
        t = 0;
        while (!(write && int'(addr) == n) && t < 4000) begin
            step();
            t++;
        end
        if (t >= 4000) timeout_fail("wait_addr");
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 20000) begin
            step();
            t++;
        end
        if (t >= 20000) timeout_fail("wait_idle");
    endtask

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        switch_img = 1'b0;
        mode = 2'b00;
        wr_ready = 1'b1;
`ifdef PATGEN_DIM_EN
        dim = 2'b00;
`endif
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();
        chk("idle_write", int'(write), 0);
        chk("idle_display", int'(display), 0);
        chk("idle_busy", int'(busy), 0);

        // frame 1: static with a 3-cycle stall at addr 100
        pulse_tick();
        chk("f1_addr0", int'(addr), 0);
        chk("f1_rom_addr0", int'(rom_addr), 0);
        wait_addr(100);
        wr_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_addr", int'(addr), 100);
            chk("stall_write", int'(write), 1);
            chk("stall_rgb", int'(rgb), int'(rom_fn(3'd0, 9'd100)));
        end
        wr_ready = 1'b1;
        wait_idle();
        chk("f1_display", int'(display), 1);

        // frames 2..4
        repeat (3) begin
            pulse_tick();
            wait_idle();
        end

        // frame 5: scroll left, offset 1
        mode = 2'b01;
        pulse_tick();
        chk("left_rom_addr0", int'(rom_addr), 9'h01F);
        wait_idle();

        // frame 6: diagonal, image switch and overrun mid-frame
        mode = 2'b11;
        pulse_tick();
        chk("diag_rom_addr0", int'(rom_addr), 9'h1FF);
        wait_addr(200);
        switch_img = 1'b1;
        step();
        switch_img = 1'b0;
        wait_addr(250);
        chk("img_held", int'(rom_img), 0);
        wait_addr(300);
        pulse_tick();
        chk("overrun_hi", int'(overrun), 1);
        step();
        chk("overrun_lo", int'(overrun), 0);
        chk("fill_continues", int'(busy), 1);
        wait_idle();
        chk("f6_display", int'(display), 0);

        // frame 7: new image takes effect, then reset mid-fill
        mode = 2'b00;
        pulse_tick();
        chk("img_new", int'(rom_img), 1);
        wait_addr(400);
        reset = 1'b1;
        #1;
        chk("midrst_write", int'(write), 0);
        chk("midrst_display", int'(display), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // randomized phase
        for (int c = 0; c < 14000; c++) begin
            wr_ready = ($urandom % 4) != 0;
            if ($urandom % 200 == 0) mode = 2'($urandom % 4);
            switch_img = ($urandom % 60) == 0;
            frame_tick = busy ? (($urandom % 500) == 0) : (($urandom % 8) == 0);
`ifdef PATGEN_DIM_EN
            dim = 2'($urandom % 4);
`endif
            step();
        end
        frame_tick = 1'b0;
        switch_img = 1'b0;
        wr_ready = 1'b1;
        wait_idle();
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
